decoder_hold: RTL

DECODER_HOLD -- requirements
Module: decoder_hold

---
 rtl/decoder_hold.sv | 116 +++++++++++
 1 files changed

// File: rtl/decoder_hold.sv
// decoder_hold: 3-to-8 line decoder whose output line is held for HOLD cycles.
// A code is accepted only in IDLE. A valid code lights one line of y, then
// the block sits in HOLD for HOLD cycles and ignores its input meanwhile.
// An accepted code with its valid flag clear raises a one-cycle err pulse.
// Optional build macro: DECODER_STICKY_EN. When it is defined, decoded lines
// accumulate into y and stay set until clr or reset.
module decoder_hold #(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] x,
  input  logic       clr,
  output logic       in_ready,
  output logic [7:0] y,
  output logic       busy,
  output logic       err,
  output logic [7:0] cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // The counter starts at HOLD-1 and the block leaves HOLD when it reaches 0,
  // so y stays high for exactly HOLD cycles.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);

  state_t     state_reg, state_next;
  logic [7:0] y_reg, y_next;
  logic [7:0] hold_reg, hold_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       err_reg, err_next;
  logic [7:0] onehot;
  logic       transfer;

  // One-hot decode of the line index.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
      assign onehot[gi] = (x[2:0] == 3'(gi));
    end
  endgenerate

  assign in_ready = (state_reg == ST_IDLE);
  assign busy     = (state_reg == ST_HOLD);
  assign transfer = in_valid & in_ready;
  assign y        = y_reg;
  assign err      = err_reg;
  assign cnt      = cnt_reg;

  // Next-state and datapath: clr wins over everything except reset.
  always_comb begin
    state_next = state_reg;
    y_next     = y_reg;
    hold_next  = hold_reg;
    cnt_next   = cnt_reg;
    err_next   = 1'b0;
    if (clr) begin
      state_next = ST_IDLE;
      y_next     = 8'h00;
      hold_next  = 8'h00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (transfer) begin
            if (x[3]) begin
              state_next = ST_HOLD;
              hold_next  = HOLD_LOAD;
              cnt_next   = cnt_reg + 8'd1;
`ifdef DECODER_STICKY_EN
              y_next     = y_reg | onehot;
`else
              y_next     = onehot;
`endif
            end else begin
              err_next = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (hold_reg == 8'h00) begin
            state_next = ST_IDLE;
`ifndef DECODER_STICKY_EN
            y_next     = 8'h00;
`endif
          end else begin
            hold_next = hold_reg - 8'd1;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      y_reg     <= 8'h00;
      hold_reg  <= 8'h00;
      cnt_reg   <= 8'h00;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      y_reg     <= y_next;
      hold_reg  <= hold_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

endmodule
